// File: rtl/fp_div_seq.sv
// IEEE-754 single-precision divider (a / b) using restoring mantissa division, truncating.
// Latency: accept edge k; result and done at edge k+26 (special operands: edge k+1).
// Backpressure: start is sampled only in IDLE and ignored while a division is in flight.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start, a, b       request and operands (latched on the accept edge)
//   busy              high while mantissa iterations are running
//   done              one-cycle pulse; out and flags are valid from this cycle
//   out               quotient, held until the next done
//   overflow          non-finite result (exponent >= 255 or Inf/NaN operand)
//   underflow         result exponent <= 0, out flushed to +0
//   div_by_zero       nonzero dividend divided by zero
module fp_div_seq #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPEC = 2'd1,
        DIV  = 2'd2,
        NORM = 2'd3
    } state_t;

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    state_t      state;
    state_t      state_nxt;

    // Only sign and exponents are needed after the accept edge; the
    // mantissas live on in the remainder and divisor registers.
    logic        sign_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic [24:0] rem;
    logic [23:0] dvs;
    logic [24:0] quo;
    logic [4:0]  count;

    logic        in_special;
    logic        rem_ge;
    logic [24:0] rem_nxt;

    logic [31:0] spec_out;
    logic        spec_ov;
    logic        spec_dz;

    logic signed [9:0] e_norm;
    logic [22:0] mant;
    logic [31:0] norm_out;
    logic        norm_ov;
    logic        norm_uf;

    // Special classification on the raw inputs decides SPEC vs DIV at accept.
    assign in_special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
                        (a[30:23] == 8'h00) || (b[30:23] == 8'h00);

    // One restoring step. rem stays below 2*dvs, so 25 bits never overflow.
    assign rem_ge  = (rem >= {1'b0, dvs});
    assign rem_nxt = rem_ge ? ((rem - {1'b0, dvs}) << 1) : (rem << 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = in_special ? SPEC : DIV;
            SPEC: state_nxt = IDLE;
            DIV:  if (count == 5'd24) state_nxt = NORM;
            NORM: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Special-operand result; first match wins, and a zero quotient is +0.
    always_comb begin
        spec_out = 32'h0000_0000;
        spec_ov  = 1'b0;
        spec_dz  = 1'b0;
        if ((ea_q == 8'hFF) || (eb_q == 8'hFF)) begin
            spec_out = {sign_q, 8'hFF, 23'h0};
            spec_ov  = 1'b1;
        end else if ((eb_q == 8'h00) && (ea_q != 8'h00)) begin
            spec_out = {sign_q, 8'hFF, 23'h0};
            spec_dz  = 1'b1;
        end
    end

    // Quotient lies in (0.5, 2): q[24] set means no normalising shift needed.
    always_comb begin
        e_norm   = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_S
                   - (quo[24] ? 10'sd0 : 10'sd1);
        mant     = quo[24] ? quo[23:1] : quo[22:0];
        norm_out = {sign_q, e_norm[7:0], mant};
        norm_ov  = 1'b0;
        norm_uf  = 1'b0;
        if (e_norm >= 10'sd255) begin
            norm_out = {sign_q, 8'hFF, 23'h0};
            norm_ov  = 1'b1;
        end else if (e_norm <= 10'sd0) begin
            norm_out = 32'h0000_0000;
            norm_uf  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            out         <= 32'h0000_0000;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            sign_q      <= 1'b0;
            ea_q        <= 8'h00;
            eb_q        <= 8'h00;
            rem         <= 25'h0;
            dvs         <= 24'h0;
            quo         <= 25'h0;
            count       <= 5'd0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q      <= a[31] ^ b[31];
                        ea_q        <= a[30:23];
                        eb_q        <= b[30:23];
                        rem         <= {2'b01, a[22:0]};
                        dvs         <= {1'b1, b[22:0]};
                        quo         <= 25'h0;
                        count       <= 5'd0;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                SPEC: begin
                    out         <= spec_out;
                    overflow    <= spec_ov;
                    underflow   <= 1'b0;
                    div_by_zero <= spec_dz;
                    done        <= 1'b1;
                end
                DIV: begin
                    busy  <= 1'b1;
                    rem   <= rem_nxt;
                    quo   <= {quo[23:0], rem_ge};
                    count <= count + 5'd1;
                end
                NORM: begin
                    busy        <= 1'b0;
                    out         <= norm_out;
                    overflow    <= norm_ov;
                    underflow   <= norm_uf;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
